// File: rtl/mem_ctl_pkg.sv
// Shared ring definitions: slot type encodings and ADDR slot field positions
// used by every block that snoops the ring.
package mem_ctl_pkg;

  localparam int SLOT_TYPE_W = 4;

  localparam logic [SLOT_TYPE_W-1:0] SLOT_EMPTY = 4'd0;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_ADDR  = 4'd1;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_WDATA = 4'd2;

  localparam int ADDR_CTYPE_BIT = 31;
  localparam int ADDR_WRITE_BIT = 30;
  localparam int ADDR_LINE_TOP  = 29;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: a push while full is accepted only if a pop happens in the
// same cycle; otherwise it is dropped and the sticky overflow flag is set.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int NBQ   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             push_ok,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int           DEPTH   = 2 ** NBQ;
  localparam logic [NBQ:0] DEPTH_V = (NBQ + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [NBQ-1:0]   wptr_q, rptr_q;
  logic [NBQ:0]     count_q;
  logic             overflow_q;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_V);
  assign do_pop   = pop && !empty;
  assign push_ok  = push && (!full || do_pop);
  assign dout     = mem_q[rptr_q];
  assign overflow = overflow_q;

  // NOTE: sequential state is updated with <= only, so every reader in this
  // cycle sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{NBQ{1'b0}}, push_ok} - {{NBQ{1'b0}}, do_pop};
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which entries are valid, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mem_ctl.sv
// Ring memory controller: snoops ADDR/WDATA slots, queues line commands and
// bursts whole lines to/from backing memory, streaming read words to caches.
module mem_ctl
  import mem_ctl_pkg::*;
#(
  parameter int TSIZE   = 4,
  parameter int NBWORDS = 3,
  parameter int NBQ     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TSIZE-1:0]   slot_type,
  input  logic [31:0]        slot_data,
  output logic               mc_ack,
  output logic [NBWORDS-1:0] mc_count,
  output logic [31:0]        mc_data,
  output logic [29:0]        mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ack,
  output logic               overflow
);

  localparam int                 NWORDS = 2 ** NBWORDS;
  localparam int                 LW     = 30 - NBWORDS;
  localparam int                 CMD_W  = LW + 3;
  localparam logic [NBWORDS-1:0] LAST   = NBWORDS'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  state_e             state_q;
  logic [NBWORDS-1:0] cnt_q, wfill_q, mc_count_q;
  logic [LW-1:0]      line_q;
  logic               rbuf_q, fill_q, wovf_q, mc_ack_q;
  logic [1:0]         pend_q;
  logic [31:0]        mc_data_q;
  logic [31:0]        wbuf_q [2][NWORDS];

  logic             is_addr, is_wdata, is_wr_addr, wbuf_busy, cmd_push, push_ok;
  logic             fifo_full, fifo_empty, fifo_ovf, drain_done, unused_bits;
  logic [CMD_W-1:0] push_cmd, head;

  assign is_addr    = (slot_type == TSIZE'(SLOT_ADDR));
  assign is_wdata   = (slot_type == TSIZE'(SLOT_WDATA));
  assign is_wr_addr = is_addr && slot_data[ADDR_WRITE_BIT];
  assign wbuf_busy  = pend_q[fill_q];
  assign cmd_push   = is_addr && !(is_wr_addr && wbuf_busy);
  assign push_cmd   = {slot_data[ADDR_WRITE_BIT], slot_data[ADDR_CTYPE_BIT],
                       fill_q, slot_data[LW-1:0]};

  cmd_fifo #(.WIDTH(CMD_W), .NBQ(NBQ)) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_push),
    .din      (push_cmd),
    .pop      (state_q == S_IDLE),
    .dout     (head),
    .push_ok  (push_ok),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  // ctype travels with the command for downstream use but drives no output here.
  assign unused_bits = ^{slot_data[ADDR_LINE_TOP:LW], head[CMD_W-2], fifo_full};

  assign drain_done = (state_q == S_WRITE) && mem_ack && (cnt_q == LAST);

  // Fill side: the buffer being filled is frozen by a write ADDR and stays
  // pending until the FSM has drained its last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wfill_q <= '0;
      fill_q  <= 1'b0;
      pend_q  <= '0;
      wovf_q  <= 1'b0;
    end else begin
      if (is_wdata) wfill_q <= wfill_q + 1'b1;
      if (is_wr_addr) begin
        if (wbuf_busy) begin
          wovf_q <= 1'b1;
        end else if (push_ok) begin
          pend_q[fill_q] <= 1'b1;
          fill_q         <= ~fill_q;
          wfill_q        <= '0;
        end
      end
      if (drain_done) pend_q[rbuf_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (is_wdata) wbuf_q[fill_q][wfill_q] <= slot_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      rbuf_q     <= 1'b0;
      mc_ack_q   <= 1'b0;
      mc_count_q <= '0;
      mc_data_q  <= '0;
    end else begin
      mc_ack_q <= (state_q == S_READ) && mem_ack;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!fifo_empty) begin
            line_q  <= head[LW-1:0];
            rbuf_q  <= head[CMD_W-3];
            state_q <= head[CMD_W-1] ? S_WRITE : S_READ;
          end
        end
        S_WRITE: if (mem_ack) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_IDLE;
        end
        S_READ: if (mem_ack) begin
          mc_data_q  <= mem_rdata;
          mc_count_q <= cnt_q;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd    = (state_q == S_READ);
  assign mem_wr    = (state_q == S_WRITE);
  assign mem_addr  = {line_q, cnt_q};
  assign mem_wdata = wbuf_q[rbuf_q][cnt_q];
  assign mc_ack    = mc_ack_q;
  assign mc_count  = mc_count_q;
  assign mc_data   = mc_data_q;
  assign overflow  = fifo_ovf | wovf_q;

endmodule

// File: tb/tb_mem_ctl.sv
// Bench for mem_ctl: directed scenarios plus randomized command groups, all
// checked against a line-level memory model and expected-transaction queues.
module tb_mem_ctl;
  import mem_ctl_pkg::*;

  localparam int NBWORDS = 3;
  localparam int NWORDS  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  slot_type;
  logic [31:0] slot_data;
  logic        mc_ack;
  logic [2:0]  mc_count;
  logic [31:0] mc_data;
  logic [29:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        overflow;

  always #5 clk = ~clk;

  mem_ctl #(.TSIZE(4), .NBWORDS(NBWORDS), .NBQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .slot_type (slot_type),
    .slot_data (slot_data),
    .mc_ack    (mc_ack),
    .mc_count  (mc_count),
    .mc_data   (mc_data),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .overflow  (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Backing memory seen by the DUT, and the bench's view of what it should hold.
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'hC001D00D;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  logic [29:0] exp_rd [$];
  logic [61:0] exp_wr [$];
  logic [34:0] exp_mc [$];

  int ack_mode = 0;  // 0 every cycle, 1 random, 2 every 3rd cycle, 3 held low
  int cyc = 0;
  int last_mc_cyc = 0;
  int mc_seen = 0;

  task automatic tick();
    logic [34:0] e;
    logic [61:0] w;
    bit ack;
    @(posedge clk);
    #1;
    cyc++;
    if (mc_ack) begin
      mc_seen++;
      if (exp_mc.size() == 0) check("spurious_mc_ack", 1, 0);
      else begin
        e = exp_mc.pop_front();
        check("mc_count", mc_count, e[34:32]);
        check("mc_data", mc_data, e[31:0]);
      end
      if (ack_mode == 2 && mc_count != 0) check("mc_gap", cyc - last_mc_cyc, 3);
      last_mc_cyc = cyc;
    end
    if (mem_rd && mem_wr) check("rd_wr_exclusive", 1, 0);
    case (ack_mode)
      0:       ack = 1'b1;
      1:       ack = 1'($urandom_range(0, 1));
      2:       ack = (cyc % 3 == 0);
      default: ack = 1'b0;
    endcase
    mem_ack   = ack;
    mem_rdata = $urandom;
    if (ack && mem_rd) begin
      if (exp_rd.size() == 0) check("unexpected_rd", 1, 0);
      else check("rd_addr", mem_addr, exp_rd.pop_front());
      mem_rdata = mem_word(mem_addr);
    end
    if (ack && mem_wr) begin
      if (exp_wr.size() == 0) check("unexpected_wr", 1, 0);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", mem_addr, w[61:32]);
        check("wr_data", mem_wdata, w[31:0]);
      end
      mem[mem_addr] = mem_wdata;
    end
  endtask

  task automatic send_slot(input logic [3:0] t, input logic [31:0] d);
    slot_type = t;
    slot_data = d;
    tick();
    slot_type = SLOT_EMPTY;
    slot_data = $urandom;
  endtask

  task automatic junk_slot();
    send_slot(4'($urandom_range(3, 15)), $urandom);
  endtask

  task automatic issue_read(input logic [26:0] line, input bit ctype, input bit accepted);
    send_slot(SLOT_ADDR, {ctype, 1'b0, 3'b000, line});
    if (accepted) begin
      for (int i = 0; i < NWORDS; i++) begin
        exp_rd.push_back({line, 3'(i)});
        exp_mc.push_back({3'(i), ref_word({line, 3'(i)})});
      end
    end
  endtask

  task automatic issue_write(input logic [26:0] line, input logic [31:0] d [NWORDS], input bit noisy);
    for (int i = 0; i < NWORDS; i++) begin
      send_slot(SLOT_WDATA, d[i]);
      if (noisy && $urandom_range(0, 3) == 0) junk_slot();
    end
    send_slot(SLOT_ADDR, {2'b01, 3'b000, line});
    for (int i = 0; i < NWORDS; i++) begin
      exp_wr.push_back({line, 3'(i), d[i]});
      ref_mem[{line, 3'(i)}] = d[i];
    end
  endtask

  task automatic clear_expect();
    exp_rd.delete();
    exp_wr.delete();
    exp_mc.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rd.size() + exp_wr.size() + exp_mc.size()) != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      check({tag, "_timeout"}, 1, 0);
      clear_expect();
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_expect();
  endtask

  logic [31:0] wd [NWORDS];

  initial begin
    reset     = 1'b1;
    slot_type = SLOT_EMPTY;
    slot_data = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    do_reset();
    check("reset_mc_ack", mc_ack, 0);
    check("reset_mem_rd", mem_rd, 0);
    check("reset_mem_wr", mem_wr, 0);
    check("reset_overflow", overflow, 0);

    // Idle with an empty queue and junk slots: no memory traffic.
    ack_mode = 1;
    repeat (6) junk_slot();
    check("idle_mem_rd", mem_rd, 0);
    check("idle_mem_wr", mem_wr, 0);

    // Single line read, memory acking every cycle.
    ack_mode = 0;
    issue_read(27'h10, 1'b0, 1'b1);
    drain("read_line");

    // Line write of 0xA0..0xA7 to line 5.
    for (int i = 0; i < NWORDS; i++) wd[i] = 32'hA0 + i;
    issue_write(27'h5, wd, 1'b0);
    drain("write_line");

    // Write then read of line 5 back-to-back, from a scrubbed memory line.
    for (int i = 0; i < NWORDS; i++) begin
      mem.delete({27'h5, 3'(i)});
      ref_mem.delete({27'h5, 3'(i)});
    end
    issue_write(27'h5, wd, 1'b0);
    issue_read(27'h5, 1'b1, 1'b1);
    drain("write_then_read");

    // Overflow: FSM stalled on a write, four reads fill the queue, fifth drops.
    ack_mode = 3;
    for (int i = 0; i < NWORDS; i++) wd[i] = $urandom;
    issue_write(27'h7, wd, 1'b0);
    for (int k = 0; k < 4; k++) issue_read(27'h20 + 27'(k), 1'b0, 1'b1);
    check("ovf_after_4", overflow, 0);
    issue_read(27'h24, 1'b0, 1'b0);
    check("ovf_after_5", overflow, 1);
    ack_mode = 0;
    drain("overflow_drain");
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_reset", overflow, 0);

    // Stalled memory: ack every third cycle.
    ack_mode = 2;
    issue_read(27'h11, 1'b0, 1'b1);
    drain("stalled_read");

    // Reset in the middle of a read burst.
    ack_mode = 0;
    mc_seen  = 0;
    issue_read(27'h33, 1'b0, 1'b1);
    for (int n = 0; n < 100 && mc_seen < 3; n++) tick();
    check("mid_burst_seen3", mc_seen, 3);
    do_reset();
    for (int n = 0; n < 5; n++) begin
      tick();
      check("abort_mc_ack", mc_ack, 0);
      check("abort_mem_rd", mem_rd | mem_wr, 0);
    end
    check("abort_overflow", overflow, 0);
    issue_read(27'h33, 1'b0, 1'b1);
    drain("read_after_abort");

    // Randomized groups: up to three commands, at most two writes, then drain.
    ack_mode = 1;
    for (int g = 0; g < 40; g++) begin
      int ncmd = $urandom_range(1, 3);
      int nwr  = 0;
      for (int c = 0; c < ncmd; c++) begin
        if (nwr < 2 && $urandom_range(0, 1) == 1) begin
          for (int i = 0; i < NWORDS; i++) wd[i] = $urandom;
          issue_write(27'($urandom_range(0, 7)), wd, 1'b1);
          nwr++;
        end else begin
          issue_read(27'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
        end
        if ($urandom_range(0, 2) == 0) junk_slot();
      end
      drain("random_group");
      check("random_overflow", overflow, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
